// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the nibble-serial adder sequencer.
// The master side requests operations; the slave side is the sequencer itself.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int WIDTH = 4 * NIBBLES;

    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, op_sub, a, b,
        input  ready, done, result, c_out, overflow
    );

    modport slave (
        input  start, op_sub, a, b,
        output ready, done, result, c_out, overflow
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer. One 4-bit ripple-carry slice is reused
// once per clock, LSB nibble first; the inter-nibble carry lives in a flop and
// the operands sit in right-shifting registers. Subtraction is a + ~b + 1.

// Plain 4-bit ripple-carry slice exposing the carry out of every bit position.
module nibble_add_slice (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic [3:0] o_carry
);
    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < 4; g++) begin : g_fa
        assign o_sum[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_carry = w_c[4:1];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int CW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_c_out;
    logic             r_overflow;
    logic             r_ready;
    logic             r_done;

    logic [3:0]       w_sum;
    logic [3:0]       w_slice_carry;
    logic [1:0]       w_unused_carry_lo;

    nibble_add_slice u_slice (
        .i_a     (r_a_sh[3:0]),
        .i_b     (r_b_sh[3:0]),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_carry (w_slice_carry)
    );

    // Only the top two bit carries matter: bit 3 is the carry chain, bit 2 feeds overflow.
    assign w_unused_carry_lo = w_slice_carry[1:0];

    assign w_last = (r_cnt == CW'(NIBBLES - 1));

    // Next-state decode and accept qualification (accept only while ready).
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake outputs registered from the next state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_next_state != S_RUN);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    // Operand shift registers, carry flop, nibble counter and result/flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh     <= {WIDTH{1'b0}};
            r_b_sh     <= {WIDTH{1'b0}};
            r_carry    <= 1'b0;
            r_cnt      <= {CW{1'b0}};
            r_result   <= {WIDTH{1'b0}};
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.op_sub ? ~bus.b : bus.b;
            r_carry  <= bus.op_sub;
            r_cnt    <= {CW{1'b0}};
            r_result <= {WIDTH{1'b0}};
        end else if (r_state == S_RUN) begin
            r_carry  <= w_slice_carry[3];
            r_result <= {w_sum, r_result[WIDTH-1:4]};
            r_a_sh   <= {4'b0000, r_a_sh[WIDTH-1:4]};
            r_b_sh   <= {4'b0000, r_b_sh[WIDTH-1:4]};
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_c_out    <= w_slice_carry[3];
                r_overflow <= w_slice_carry[2] ^ w_slice_carry[3];
            end
        end
    end

    assign bus.ready    = r_ready;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.c_out    = r_c_out;
    assign bus.overflow = r_overflow;
endmodule
